// File: rtl/piso_pkg.sv
// Shared constants and types for the parallel-in/serial-out serializer.
package piso_pkg;

  // State encodings
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Legal word width range
  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 32;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } piso_state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] pi;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             so;
  logic             so_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  // Word source / bit-rate generator side
  modport master (
    output pi, load_valid, shift_en,
    input  load_ready, so, so_valid, frame_start, frame_end, busy
  );

  // Serializer side
  modport slave (
    input  pi, load_valid, shift_en,
    output load_ready, so, so_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/piso_bit_cnt.sv
// Bit position counter: clear has priority, saturates at Width-1 and flags it.
module piso_bit_cnt #(
  parameter int unsigned Width = 4,
  localparam int unsigned CntW = $clog2(Width)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CntW-1:0] TcVal = CntW'(Width - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Terminal count marks the last bit of the frame
  assign tc_o = (cnt_q == TcVal);

  // Next count: clear wins, never advance past the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with framing strobes and gapless back-to-back frames.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst,
  piso_serializer_if.slave  bus
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("piso_serializer: WIDTH out of range");
  end

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shreg_shift;
  logic             so_q, so_d;
  logic             so_valid_q, so_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic             load_ready, accept;

  // Bit that goes on the line first from a given word
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Shift toward the output end so the next bit sits at the head position
  always_comb begin
    if (MSB_FIRST) begin
      shreg_shift = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_shift = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  piso_bit_cnt #(
    .Width (WIDTH)
  ) u_bit_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_o   (cnt_tc)
  );

  // Ready while idle, or on the last bit when it is actually leaving this cycle
  assign load_ready = (state_q == StIdle) || ((state_q == StShift) && cnt_tc && bus.shift_en);
  assign accept     = bus.load_valid && load_ready;

  // Next-state and output-register logic
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    so_d          = so_q;
    so_valid_d    = so_valid_q;
    frame_start_d = frame_start_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d       = StShift;
          shreg_d       = bus.pi;
          so_d          = head_bit(bus.pi);
          so_valid_d    = 1'b1;
          frame_start_d = 1'b1;
          cnt_clr       = 1'b1;
        end
      end
      StShift: begin
        // Without shift_en everything holds
        if (bus.shift_en) begin
          if (!cnt_tc) begin
            shreg_d       = shreg_shift;
            so_d          = head_bit(shreg_shift);
            frame_start_d = 1'b0;
            cnt_en        = 1'b1;
          end else if (accept) begin
            // Chain the next frame straight after the last bit
            shreg_d       = bus.pi;
            so_d          = head_bit(bus.pi);
            so_valid_d    = 1'b1;
            frame_start_d = 1'b1;
            cnt_clr       = 1'b1;
          end else begin
            state_d       = StIdle;
            so_d          = 1'b0;
            so_valid_d    = 1'b0;
            frame_start_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      so_q          <= 1'b0;
      so_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      so_q          <= so_d;
      so_valid_q    <= so_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.so          = so_q;
  assign bus.so_valid    = so_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = (state_q == StShift) && cnt_tc;
  assign bus.busy        = (state_q == StShift);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: MSB-first and LSB-first instances fed identical stimulus.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pi;
  logic       load_valid;
  logic       shift_en;

  int n_tests = 0;
  int n_fail  = 0;

  piso_serializer_if #(.WIDTH(4)) bus_m ();
  piso_serializer_if #(.WIDTH(4)) bus_l ();

  assign bus_m.pi         = pi;
  assign bus_m.load_valid = load_valid;
  assign bus_m.shift_en   = shift_en;
  assign bus_l.pi         = pi;
  assign bus_l.load_valid = load_valid;
  assign bus_l.shift_en   = shift_en;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check the MSB-first instance
  task automatic step(input string tag, input logic lv, input logic [3:0] p, input logic se,
                      input logic e_so, input logic e_sv, input logic e_fs, input logic e_fe,
                      input logic e_rdy);
    @(negedge clk);
    load_valid = lv;
    pi         = p;
    shift_en   = se;
    #1;
    check({tag, ".so"},    32'(bus_m.so),          32'(e_so));
    check({tag, ".sv"},    32'(bus_m.so_valid),    32'(e_sv));
    check({tag, ".busy"},  32'(bus_m.busy),        32'(e_sv));
    check({tag, ".fs"},    32'(bus_m.frame_start), 32'(e_fs));
    check({tag, ".fe"},    32'(bus_m.frame_end),   32'(e_fe));
    check({tag, ".rdy"},   32'(bus_m.load_ready),  32'(e_rdy));
  endtask

  initial begin
    logic [7:0] b2b_so;
    logic [6:0] st_se, st_lv, st_so, st_fe, st_rdy;
    int         fs_cnt;

    rst        = 1'b1;
    pi         = 4'h0;
    load_valid = 1'b0;
    shift_en   = 1'b0;
    #2 rst = 1'b0;

    // Reset state; loads offered during reset are ignored
    step("rst0", 1'b1, 4'hF, 1'b1, 0, 0, 0, 0, 1);
    step("rst1", 1'b1, 4'hF, 1'b1, 0, 0, 0, 0, 1);
    check("rst1.l_sv", 32'(bus_l.so_valid), 32'd0);
    @(negedge clk);
    rst        = 1'b1;
    load_valid = 1'b0;

    // Single frame 4'b1011: MSB 1,0,1,1 / LSB 1,1,0,1
    step("s.ld", 1'b1, 4'hB, 1'b1, 0, 0, 0, 0, 1);
    step("s.b0", 1'b0, 4'h0, 1'b1, 1, 1, 1, 0, 0);
    check("s.b0.l_so", 32'(bus_l.so), 32'd1);
    check("s.b0.l_fs", 32'(bus_l.frame_start), 32'd1);
    step("s.b1", 1'b0, 4'h0, 1'b1, 0, 1, 0, 0, 0);
    check("s.b1.l_so", 32'(bus_l.so), 32'd1);
    step("s.b2", 1'b0, 4'h0, 1'b1, 1, 1, 0, 0, 0);
    check("s.b2.l_so", 32'(bus_l.so), 32'd0);
    step("s.b3", 1'b0, 4'h0, 1'b1, 1, 1, 0, 1, 1);
    check("s.b3.l_so", 32'(bus_l.so), 32'd1);
    check("s.b3.l_fe", 32'(bus_l.frame_end), 32'd1);
    step("s.end", 1'b0, 4'h0, 1'b1, 0, 0, 0, 0, 1);
    check("s.end.l_sv", 32'(bus_l.so_valid), 32'd0);

    // Backpressure: changing pi while busy must not leak onto so (9 = 1,0,0,1)
    step("bp.ld", 1'b1, 4'h9, 1'b1, 0, 0, 0, 0, 1);
    step("bp.b0", 1'b1, 4'hF, 1'b1, 1, 1, 1, 0, 0);
    step("bp.b1", 1'b1, 4'hE, 1'b1, 0, 1, 0, 0, 0);
    step("bp.b2", 1'b1, 4'h7, 1'b1, 0, 1, 0, 0, 0);
    step("bp.b3", 1'b0, 4'h6, 1'b1, 1, 1, 0, 1, 1);
    step("bp.end", 1'b0, 4'h0, 1'b1, 0, 0, 0, 0, 1);

    // Back-to-back A then 5 with no gap
    b2b_so = 8'b1010_0101;
    fs_cnt = 0;
    step("bb.ld", 1'b1, 4'hA, 1'b1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step($sformatf("bb.%0d", i), (i < 4), 4'h5, 1'b1, b2b_so[7-i], 1,
           (i == 0 || i == 4), (i == 3 || i == 7), (i == 3 || i == 7));
      if (bus_m.frame_start) fs_cnt++;
    end
    check("bb.fs_cnt", 32'(fs_cnt), 32'd2);
    step("bb.end", 1'b0, 4'h0, 1'b1, 0, 0, 0, 0, 1);

    // Stall: 4'b1100 with shift_en low for 3 cycles after bit 1
    st_se  = 7'b1110001;  // index 0 is bit 0 of each vector
    st_lv  = 7'b0001110;
    st_so  = 7'b0011111;
    st_fe  = 7'b1000000;
    st_rdy = 7'b1000000;
    step("st.ld", 1'b1, 4'hC, 1'b1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step($sformatf("st.%0d", i), st_lv[i], 4'hF, st_se[i], st_so[i], 1, (i == 0),
           st_fe[i], st_rdy[i]);
    end
    step("st.end", 1'b0, 4'h0, 1'b1, 0, 0, 0, 0, 1);

    // Reset during bit 2 of 4'b1111 clears outputs before the next edge
    step("rr.ld", 1'b1, 4'hF, 1'b1, 0, 0, 0, 0, 1);
    step("rr.b0", 1'b0, 4'h0, 1'b1, 1, 1, 1, 0, 0);
    step("rr.b1", 1'b0, 4'h0, 1'b1, 1, 1, 0, 0, 0);
    step("rr.b2", 1'b0, 4'h0, 1'b1, 1, 1, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("rr.async.so",   32'(bus_m.so),       32'd0);
    check("rr.async.sv",   32'(bus_m.so_valid), 32'd0);
    check("rr.async.busy", 32'(bus_m.busy),     32'd0);
    @(negedge clk);
    rst = 1'b1;
    step("rr.idle", 1'b0, 4'h0, 1'b1, 0, 0, 0, 0, 1);
    step("rr.ld2", 1'b1, 4'h1, 1'b1, 0, 0, 0, 0, 1);
    step("rr.c0", 1'b0, 4'h0, 1'b1, 0, 1, 1, 0, 0);
    step("rr.c1", 1'b0, 4'h0, 1'b1, 0, 1, 0, 0, 0);
    step("rr.c2", 1'b0, 4'h0, 1'b1, 0, 1, 0, 0, 0);
    step("rr.c3", 1'b0, 4'h0, 1'b1, 1, 1, 0, 1, 1);
    step("rr.end", 1'b0, 4'h0, 1'b1, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
